// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, defaults and address checking for the data-memory responder
package dmem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam int unsigned DEF_DATA_W      = 32;
   localparam int unsigned DEF_ADDR_W      = 32;
   localparam int unsigned DEF_DEPTH_WORDS = 1024;
   localparam int unsigned DEF_LATENCY     = 4;

   // True when the byte address is word aligned and its word index lies inside the array.
   // Any address bit above the index field makes the index too large, so nothing wraps.
   function automatic logic addr_ok(input logic [63:0] addr, input logic [63:0] depth_words);
      logic [63:0] word_idx;
      word_idx = addr >> 2;
      return (addr[1:0] == 2'b00) && (word_idx < depth_words);
   endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port synchronous RAM with registered read, contents not reset
module dmem_array #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic              clk_i,
   input  logic              en_i,
   input  logic              we_i,
   input  logic [IDX_W-1:0]  addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
   logic [DATA_W-1:0] rdata_q;

   // Read returns the old word when a write hits the same address.
   always_ff @(posedge clk_i) begin
      if (en_i) begin
         if (we_i) begin
            mem_q[addr_i] <= wdata_i;
         end
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency load/store responder for the MEM stage with stall output
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DATA_W      = DEF_DATA_W,
   parameter int unsigned ADDR_W      = DEF_ADDR_W,
   parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
   parameter int unsigned LATENCY     = DEF_LATENCY
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_write_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [DATA_W-1:0] req_wdata_i,
   output logic              resp_valid_o,
   input  logic              resp_ready_i,
   output logic [DATA_W-1:0] resp_rdata_o,
   output logic              resp_err_o,
   output logic              stall_o
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
   localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                write_q, write_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                err_q, err_d;

   logic                addr_good;
   logic                last_busy;
   logic                ram_en;
   logic                ram_we;
   logic [DATA_W-1:0]   ram_rdata;

   assign addr_good = addr_ok(64'(addr_q), 64'(DEPTH_WORDS));
   assign last_busy = (state_q == ST_BUSY) && (cnt_q == '0);

   // The array is touched only on the final busy edge, and never for a faulting address.
   assign ram_en = last_busy && addr_good;
   assign ram_we = ram_en && write_q;

   dmem_array #(
      .DATA_W      (DATA_W),
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_array (
      .clk_i   (clk_i),
      .en_i    (ram_en),
      .we_i    (ram_we),
      .addr_i  (addr_q[IDX_W+1:2]),
      .wdata_i (wdata_q),
      .rdata_o (ram_rdata)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               write_d = req_write_i;
               addr_d  = req_addr_i;
               wdata_d = req_wdata_i;
               cnt_d   = CNT_W'(LATENCY - 1);
               err_d   = 1'b0;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               err_d   = !addr_good;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (resp_ready_i) begin
               err_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Read data comes straight from the array register, which holds until the next access.
   assign req_ready_o  = (state_q == ST_IDLE);
   assign resp_valid_o = (state_q == ST_RESP);
   assign resp_err_o   = (state_q == ST_RESP) && err_q;
   assign resp_rdata_o = ((state_q == ST_RESP) && !err_q && !write_q) ? ram_rdata : '0;
   assign stall_o      = (state_q == ST_BUSY)
                       | ((state_q == ST_RESP) & !resp_ready_i)
                       | ((state_q == ST_IDLE) & req_valid_i);

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed scoreboard bench for dmem_responder at LATENCY 4 and 1
module tb_dmem_responder;

   localparam int LAT4 = 4;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err, stall;
   logic [31:0] resp_rdata;

   logic        b_req_valid, b_req_ready, b_req_write;
   logic [31:0] b_req_addr, b_req_wdata;
   logic        b_resp_valid, b_resp_ready, b_resp_err, b_stall;
   logic [31:0] b_resp_rdata;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   dmem_responder #(
      .DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(1024), .LATENCY(LAT4)
   ) u_dut (
      .clk_i(clk), .rst_i(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
      .resp_rdata_o(resp_rdata), .resp_err_o(resp_err), .stall_o(stall)
   );

   dmem_responder #(
      .DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(1024), .LATENCY(1)
   ) u_dut1 (
      .clk_i(clk), .rst_i(rst_n),
      .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_write_i(b_req_write),
      .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata),
      .resp_valid_o(b_resp_valid), .resp_ready_i(b_resp_ready),
      .resp_rdata_o(b_resp_rdata), .resp_err_o(b_resp_err), .stall_o(b_stall)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with the responder idle; runs one full transaction on u_dut.
   task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input int bp, input logic exp_err, input logic [31:0] exp_rdata);
      exp_t e;
      int   n;
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wdata;
      e.err     = exp_err;
      e.rdata   = exp_rdata;
      sb.push_back(e);
      #1;
      check("stall_on_present", 32'(stall), 1);
      check("req_ready_idle", 32'(req_ready), 1);
      @(negedge clk);
      req_valid = 1'b0;
      req_addr  = 32'hFFFF_FFFF;
      check("req_ready_busy", 32'(req_ready), 0);
      check("stall_busy", 32'(stall), 1);
      n = 0;
      while (resp_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("latency", 32'(n), LAT4);
      check("sb_nonempty", 32'(sb.size()), 1);
      e = sb.pop_front();
      check("resp_rdata", resp_rdata, e.rdata);
      check("resp_err", 32'(resp_err), 32'(e.err));
      for (int i = 0; i < bp; i++) begin
         @(negedge clk);
         check("bp_valid", 32'(resp_valid), 1);
         check("bp_rdata", resp_rdata, e.rdata);
         check("bp_stall", 32'(stall), 1);
         check("bp_req_ready", 32'(req_ready), 0);
      end
      resp_ready = 1'b1;
      #1;
      check("stall_handshake", 32'(stall), 0);
      @(negedge clk);
      resp_ready = 1'b0;
      check("idle_valid", 32'(resp_valid), 0);
      check("idle_ready", 32'(req_ready), 1);
      check("idle_rdata", resp_rdata, 0);
      check("idle_err", 32'(resp_err), 0);
   endtask

   initial begin
      exp_t e;
      rst_n = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
      b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_resp_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 1);
      check("rst_resp_valid", 32'(resp_valid), 0);
      check("rst_rdata", resp_rdata, 0);
      check("rst_err", 32'(resp_err), 0);
      check("rst_stall", 32'(stall), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Preload, store/load, backpressure, misaligned, out-of-range, last word.
      txn(1'b1, 32'h20, 32'h0, 0, 1'b0, 32'h0);
      txn(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, 32'h0);
      txn(1'b0, 32'h10, 32'h0, 0, 1'b0, 32'hDEADBEEF);
      txn(1'b0, 32'h10, 32'h0, 3, 1'b0, 32'hDEADBEEF);
      txn(1'b1, 32'h13, 32'h1234, 0, 1'b1, 32'h0);
      txn(1'b0, 32'h10, 32'h0, 0, 1'b0, 32'hDEADBEEF);
      txn(1'b0, 32'h1000, 32'h0, 0, 1'b1, 32'h0);
      txn(1'b1, 32'hFFC, 32'hCAFEF00D, 0, 1'b0, 32'h0);
      txn(1'b0, 32'hFFC, 32'h0, 0, 1'b0, 32'hCAFEF00D);
      txn(1'b0, 32'h8000_0010, 32'h0, 0, 1'b1, 32'h0);

      // Reset two edges into a store: outputs drop at once, the store is lost.
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hA5A5A5A5;
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_req_ready", 32'(req_ready), 1);
      check("midrst_valid", 32'(resp_valid), 0);
      check("midrst_rdata", resp_rdata, 0);
      check("midrst_err", 32'(resp_err), 0);
      check("midrst_stall", 32'(stall), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      txn(1'b0, 32'h20, 32'h0, 0, 1'b0, 32'h0);

      // LATENCY=1 back-to-back: store A, then a held load B of the same word.
      b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 32'h8; b_req_wdata = 32'h11;
      e.err = 1'b0; e.rdata = 32'h0; sb.push_back(e);
      #1 check("b_stall_present", 32'(b_stall), 1);
      @(negedge clk);
      check("b_ready_busy", 32'(b_req_ready), 0);
      check("b_stall_busy", 32'(b_stall), 1);
      check("b_valid_busy", 32'(b_resp_valid), 0);
      b_req_write = 1'b0; b_req_wdata = 32'h0;
      e.err = 1'b0; e.rdata = 32'h11; sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      check("b_latency1_valid", 32'(b_resp_valid), 1);
      check("b_a_rdata", b_resp_rdata, e.rdata);
      check("b_a_err", 32'(b_resp_err), 32'(e.err));
      check("b_stall_resp", 32'(b_stall), 1);
      check("b_ready_resp", 32'(b_req_ready), 0);
      b_resp_ready = 1'b1;
      @(negedge clk);
      b_resp_ready = 1'b0;
      check("b_valid_after_hs", 32'(b_resp_valid), 0);
      check("b_ready_after_hs", 32'(b_req_ready), 1);
      check("b_stall_held_req", 32'(b_stall), 1);
      @(negedge clk);
      b_req_valid = 1'b0;
      check("b_b_accepted", 32'(b_req_ready), 0);
      check("b_stall_b_busy", 32'(b_stall), 1);
      @(negedge clk);
      e = sb.pop_front();
      check("b_b_valid", 32'(b_resp_valid), 1);
      check("b_b_rdata", b_resp_rdata, e.rdata);
      check("b_b_err", 32'(b_resp_err), 32'(e.err));
      check("b_stall_b_resp", 32'(b_stall), 1);
      b_resp_ready = 1'b1;
      @(negedge clk);
      b_resp_ready = 1'b0;
      check("b_final_ready", 32'(b_req_ready), 1);
      check("b_final_stall", 32'(b_stall), 0);
      check("sb_drained", 32'(sb.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder: the slave end of the CPU MEM-stage load/store interface.
- Accepts one load or store request through a valid/ready handshake.
- Waits a fixed, parameterised latency, then returns read data or a store acknowledgement through a valid/ready response handshake.
- The MEM stage stalls the pipeline on stall_o until the response is consumed.

Parameters:
- DATA_W, 32, data word width in bits.
- ADDR_W, 32, byte-address width in bits.
- DEPTH_WORDS, 1024, number of storage words; must be a power of 2.
- LATENCY, 4, cycles from request acceptance to response; must be >= 1.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  request present (MemRead or MemWrite asserted in MEM stage).
- req_ready_o  out  1  responder can accept a request.
- req_write_i  in  1  1 = store, 0 = load.
- req_addr_i  in  ADDR_W  byte address (EX/MEM ALU result).
- req_wdata_i  in  DATA_W  store data.
- resp_valid_o  out  1  response present.
- resp_ready_i  in  1  requester consumes the response.
- resp_rdata_o  out  DATA_W  load data; 0 for stores and errors.
- resp_err_o  out  1  misaligned or out-of-range access.
- stall_o  out  1  pipeline stall request.

Behaviour:
- Reset (rst_i low, asynchronous):
  - State goes to IDLE.
  - req_ready_o=1, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0, stall_o=0.
  - Latched request registers cleared. Storage contents are NOT cleared.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - req_ready_o=1.
  - On an edge with req_valid_i=1, latch write, addr and wdata, load cnt=LATENCY-1, go to BUSY.
- BUSY:
  - req_ready_o=0. Request inputs are ignored.
  - cnt>0: decrement cnt.
  - cnt==0: on the next edge go to RESP and register the response.
  - Store: write is committed to storage at this same edge, only if no error.
  - Load: resp_rdata_o = mem[addr word index], read at this edge.
- Latency: resp_valid_o is first high exactly LATENCY rising edges after the acceptance edge.
- RESP:
  - resp_valid_o=1. resp_rdata_o and resp_err_o are held stable until the handshake.
  - On an edge with resp_ready_i=1, go to IDLE and clear resp_valid_o, resp_rdata_o and resp_err_o.
  - Back-to-back: no new request is accepted in the same edge. Next acceptance is at the earliest one edge later. Maximum throughput is one request per LATENCY+2 cycles.
- stall_o (combinational):
  - = (state==BUSY) | (state==RESP & !resp_ready_i) | (state==IDLE & req_valid_i).
  - Equivalently: high from request presentation until the response handshake edge.
- Error checks, evaluated on the latched address:
  - Misaligned: addr[1:0] != 0.
  - Out of range: addr[ADDR_W-1:2] >= DEPTH_WORDS.
  - On error: resp_err_o=1, resp_rdata_o=0, store suppressed. Latency is unchanged.
- Word index = addr[2+log2(DEPTH_WORDS)-1:2]. There is no wrap-around: any higher-order address bit set is an error.
- Reset in BUSY: the pending store is discarded and storage is unchanged.
- Reset in RESP: the response is dropped. A store already committed remains.
- resp_ready_i high outside RESP: ignored.
- req_valid_i changes while not in IDLE: ignored. The requester must hold the request until it is accepted.
- Counter width: clog2(LATENCY) bits, minimum 1 bit.

Decomposition:
- dmem_pkg:
  - State enum (IDLE/BUSY/RESP).
  - Default parameter constants.
  - Function computing the word index and range check.
- Sub-module dmem_array:
  - Single-port synchronous RAM, DEPTH_WORDS x DATA_W.
  - Write-enable input; registered read in the same cycle as the write port.
  - No reset of contents.
- FSM, counter, error logic and stall logic live in dmem_responder.

Test Plan:
1. Store then load, LATENCY=4:
   - Store addr=0x10, wdata=0xDEADBEEF: resp_valid_o high 4 edges after acceptance, err=0, rdata=0.
   - Load addr=0x10: rdata=0xDEADBEEF, err=0.
2. Response backpressure:
   - Load accepted, resp_ready_i held low 3 cycles in RESP: resp_valid_o, rdata and stall_o stay high and stable; req_ready_o=0.
   - Release resp_ready_i: IDLE one edge later.
3. Misaligned store addr=0x13, wdata=0x1234:
   - err=1 after 4 edges.
   - Following load addr=0x10 still returns 0xDEADBEEF.
4. Out-of-range load addr=0x1000 (DEPTH_WORDS=1024): err=1, rdata=0.
5. Reset mid-operation:
   - Store addr=0x20, wdata=0xA5A5A5A5, rst_i low 2 edges after acceptance: outputs return to reset values immediately.
   - Load addr=0x20 returns the prior value (0x0 from preload).
6. LATENCY=1, back-to-back requests:
   - resp_valid_o 1 edge after acceptance.
   - Second held request accepted the edge after the response handshake.
   - stall_o continuously high across both transactions.
